// File: rtl/vid_gen_pkg.sv
// Shared types and the pattern generator for the synthetic video source.
// The pixel value depends only on the pattern, position and frame count.
package vid_gen_pkg;

  localparam int PIX_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_MOVING  = 2'd3
  } pattern_t;

  function automatic logic [PIX_W-1:0] pattern_pixel(
    input pattern_t         pat,
    input logic [PIX_W-1:0] x,
    input logic [PIX_W-1:0] y,
    input logic [PIX_W-1:0] fc
  );
    logic [PIX_W-1:0] pix;
    case (pat)
      PAT_HRAMP:   pix = x;
      PAT_VRAMP:   pix = y;
      PAT_CHECKER: pix = (x[4] ^ y[4]) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
      default:     pix = x + y + fc;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/vid_timing_cnt.sv
// Pixel-divider, column and line counters for one video frame.
// Exposes the position for the next clock so outputs can be registered with it.
module vid_timing_cnt #(
  parameter int PIX_DIV      = 4,
  parameter int ACTIVE_PIX   = 320,
  parameter int HBLANK_PIX   = 32,
  parameter int ACTIVE_LINES = 256,
  parameter int VBLANK_LINES = 8,
  parameter int DIV_W        = $clog2(PIX_DIV),
  parameter int X_W          = $clog2(ACTIVE_PIX + HBLANK_PIX),
  parameter int Y_W          = $clog2(ACTIVE_LINES + VBLANK_LINES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [DIV_W-1:0] div_next,
  output logic [X_W-1:0]   x_next,
  output logic [Y_W-1:0]   y_next,
  output logic             last
);

  localparam int H_TOTAL = ACTIVE_PIX + HBLANK_PIX;
  localparam int V_TOTAL = ACTIVE_LINES + VBLANK_LINES;

  logic [DIV_W-1:0] div_reg;
  logic [X_W-1:0]   x_reg;
  logic [Y_W-1:0]   y_reg;
  logic             div_wrap, x_wrap, y_wrap;

  assign div_wrap = (div_reg == DIV_W'(PIX_DIV - 1));
  assign x_wrap   = (x_reg == X_W'(H_TOTAL - 1));
  assign y_wrap   = (y_reg == Y_W'(V_TOTAL - 1));
  assign last     = div_wrap & x_wrap & y_wrap;

  // Without a step the counters collapse to the frame origin, ready for a restart.
  always_comb begin
    div_next = '0;
    x_next   = '0;
    y_next   = '0;
    if (step) begin
      div_next = div_wrap ? '0 : div_reg + 1'b1;
      x_next   = x_reg;
      y_next   = y_reg;
      if (div_wrap) begin
        x_next = x_wrap ? '0 : x_reg + 1'b1;
        if (x_wrap) begin
          y_next = y_wrap ? '0 : y_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_reg <= '0;
      x_reg   <= '0;
      y_reg   <= '0;
    end else begin
      div_reg <= div_next;
      x_reg   <= x_next;
      y_reg   <= y_next;
    end
  end

endmodule

// File: rtl/vid_pattern_gen.sv
// Test-pattern video source: run/drain FSM, registered bus outputs, frame counter.
// Frames always complete once started; only rst cuts one short.
module vid_pattern_gen
  import vid_gen_pkg::*;
#(
  parameter int PIX_DIV      = 4,
  parameter int ACTIVE_PIX   = 320,
  parameter int HBLANK_PIX   = 32,
  parameter int ACTIVE_LINES = 256,
  parameter int VBLANK_LINES = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        pattern_sel,
  output logic [PIX_W-1:0]  vid_pixel,
  output logic              vid_pixsync,
  output logic              vid_hblank,
  output logic              vid_vblank,
  output logic              frame_start,
  output logic [15:0]       frame_count,
  output logic              busy
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam int X_W   = $clog2(ACTIVE_PIX + HBLANK_PIX);
  localparam int Y_W   = $clog2(ACTIVE_LINES + VBLANK_LINES);

  state_t           state_reg, state_next;
  pattern_t         pat_reg, pat_next;
  logic [15:0]      fc_next;
  logic [DIV_W-1:0] div_next;
  logic [X_W-1:0]   x_next;
  logic [Y_W-1:0]   y_next;
  logic             last, running, step, frame_end, start;
  logic             h_act, v_act, active;

  vid_timing_cnt #(
    .PIX_DIV      (PIX_DIV),
    .ACTIVE_PIX   (ACTIVE_PIX),
    .HBLANK_PIX   (HBLANK_PIX),
    .ACTIVE_LINES (ACTIVE_LINES),
    .VBLANK_LINES (VBLANK_LINES),
    .DIV_W        (DIV_W),
    .X_W          (X_W),
    .Y_W          (Y_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .div_next (div_next),
    .x_next   (x_next),
    .y_next   (y_next),
    .last     (last)
  );

  assign running   = (state_reg != IDLE);
  assign step      = running & ~last;
  assign frame_end = running & last;
  assign start     = enable & (~running | frame_end);
  assign fc_next   = frame_end ? frame_count + 1'b1 : frame_count;
  assign pat_next  = start ? pattern_t'(pattern_sel) : pat_reg;

  // Mid-frame, enable only picks between RUN and DRAIN; the timing is identical.
  always_comb begin
    state_next = IDLE;
    if (enable)
      state_next = RUN;
    else if (step)
      state_next = DRAIN;
  end

  assign active = (state_next != IDLE);
  assign h_act  = (x_next < X_W'(ACTIVE_PIX));
  assign v_act  = (y_next < Y_W'(ACTIVE_LINES));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pat_reg     <= PAT_HRAMP;
      frame_count <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      vid_pixel   <= '0;
      vid_pixsync <= 1'b0;
      vid_hblank  <= 1'b1;
      vid_vblank  <= 1'b1;
    end else begin
      state_reg   <= state_next;
      pat_reg     <= pat_next;
      frame_count <= fc_next;
      frame_start <= start;
      busy        <= active;
      if (active) begin
        vid_hblank  <= ~h_act;
        vid_vblank  <= ~v_act;
        vid_pixsync <= (div_next == '0) & h_act & v_act;
        // Pixel value is refreshed at the start of each pixel period and held after.
        if (div_next == '0) begin
          vid_pixel <= (h_act & v_act)
                     ? pattern_pixel(pat_next, PIX_W'(x_next), PIX_W'(y_next), fc_next)
                     : '0;
        end
      end else begin
        vid_pixel   <= '0;
        vid_pixsync <= 1'b0;
        vid_hblank  <= 1'b1;
        vid_vblank  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vid_pattern_gen.sv
// Directed bench for vid_pattern_gen on a 60-clock frame with a per-cycle
// reference model of the frame timeline plus literal expectations per test.
module tb_vid_pattern_gen;

  localparam int PD    = 2;
  localparam int AP    = 4;
  localparam int HBP   = 2;
  localparam int AL    = 3;
  localparam int VBL   = 2;
  localparam int HT    = AP + HBP;
  localparam int VT    = AL + VBL;
  localparam int FRAME = PD * HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [15:0] vid_pixel;
  logic        vid_pixsync, vid_hblank, vid_vblank, frame_start, busy;
  logic [15:0] frame_count;

  vid_pattern_gen #(
    .PIX_DIV      (PD),
    .ACTIVE_PIX   (AP),
    .HBLANK_PIX   (HBP),
    .ACTIVE_LINES (AL),
    .VBLANK_LINES (VBL)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .vid_pixel   (vid_pixel),
    .vid_pixsync (vid_pixsync),
    .vid_hblank  (vid_hblank),
    .vid_vblank  (vid_vblank),
    .frame_start (frame_start),
    .frame_count (frame_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Reference model: whether a frame is in flight and the clock index inside it.
  bit m_act = 1'b0;
  int m_t   = 0;
  int m_fc  = 0;
  int m_pat = 0;

  int pix_q[$];
  int fs_q[$];
  int fc_q[$];
  int hb_cnt = 0;
  int vb_cnt = 0;
  logic [15:0] last_fc = 16'd0;

  function automatic int model_pix(input int pat, input int x, input int y, input int fc);
    case (pat)
      0:       return x;
      1:       return y;
      2:       return ((((x / 16) ^ (y / 16)) % 2) == 1) ? 32'hFFFF : 0;
      default: return (x + y + fc) % 65536;
    endcase
  endfunction

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clear_capture();
    pix_q.delete();
    fs_q.delete();
    fc_q.delete();
    hb_cnt = 0;
    vb_cnt = 0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", busy, 0);
  endtask

  always @(posedge clk) begin : model_and_compare
    int dv, xv, yv;
    bit pix_act;
    logic [15:0] e_pix;
    logic [35:0] e_vec, a_vec;

    cyc++;
    if (rst) begin
      m_act = 1'b0;
      m_fc  = 0;
    end else if (!m_act) begin
      if (enable) begin
        m_act = 1'b1;
        m_t   = 0;
        m_pat = int'(pattern_sel);
      end
    end else if (m_t == FRAME - 1) begin
      m_fc = (m_fc + 1) % 65536;
      if (enable) begin
        m_t   = 0;
        m_pat = int'(pattern_sel);
      end else begin
        m_act = 1'b0;
      end
    end else begin
      m_t++;
    end

    #1;
    if (m_act) begin
      dv      = m_t % PD;
      xv      = (m_t / PD) % HT;
      yv      = m_t / (PD * HT);
      pix_act = (xv < AP) && (yv < AL);
      e_pix   = pix_act ? 16'(model_pix(m_pat, xv, yv, m_fc)) : 16'd0;
      e_vec   = {e_pix, pix_act && (dv == 0), xv >= AP, yv >= AL, m_t == 0, 16'(m_fc), 1'b1};
    end else begin
      e_vec   = {16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'(m_fc), 1'b0};
    end
    a_vec = {vid_pixel, vid_pixsync, vid_hblank, vid_vblank, frame_start, frame_count, busy};
    n_checks++;
    if (a_vec !== e_vec) begin
      n_errors++;
      $display("FAIL cycle_model: cycle %0d got %h expected %h", cyc, a_vec, e_vec);
    end

    if (vid_pixsync) pix_q.push_back(int'(vid_pixel));
    if (frame_start) fs_q.push_back(cyc);
    if (frame_count != last_fc) fc_q.push_back(cyc);
    last_fc = frame_count;
    if (busy) begin
      hb_cnt += int'(vid_hblank);
      vb_cnt += int'(vid_vblank);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset then idle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_fc", frame_count, 0);
    check("idle_hblank", vid_hblank, 1);
    check("idle_vblank", vid_vblank, 1);
    check("idle_pixsync", vid_pixsync, 0);
    $display("[%0d] reset/idle: busy=%0d fc=%0d", cyc, busy, frame_count);

    // Single frame, horizontal ramp
    clear_capture();
    pattern_sel = 2'd0;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_idle(100);
    check("single_frames", fs_q.size(), 1);
    check("single_pixcount", pix_q.size(), 12);
    for (int i = 0; i < 12; i++) check("single_pixel", qget(pix_q, i), i % 4);
    check("single_hblank_clocks", hb_cnt, 20);
    check("single_vblank_clocks", vb_cnt, 24);
    check("single_fc", frame_count, 1);
    check("single_fc_time", qget(fc_q, 0) - qget(fs_q, 0), 60);
    $display("[%0d] single frame: pixels=%0d fc=%0d", cyc, pix_q.size(), frame_count);

    // Continuous moving ramp from a fresh frame count
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_capture();
    pattern_sel = 2'd3;
    enable = 1'b1;
    repeat (130) @(negedge clk);
    enable = 1'b0;
    wait_idle(100);
    check("cont_frames", fs_q.size(), 3);
    check("cont_period", qget(fs_q, 1) - qget(fs_q, 0), 60);
    check("cont_fc1_time", qget(fc_q, 0) - qget(fs_q, 0), 60);
    check("cont_fc2_time", qget(fc_q, 1) - qget(fs_q, 0), 120);
    check("cont_f1_x1y2", qget(pix_q, 9), 3);
    check("cont_f2_x1y2", qget(pix_q, 21), 4);
    check("cont_fc", frame_count, 3);
    $display("[%0d] continuous moving ramp: frames=%0d fc=%0d", cyc, fs_q.size(), frame_count);

    // Checker frame: all active pixels sit in the first 16x16 cell
    clear_capture();
    pattern_sel = 2'd2;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_idle(100);
    check("checker_pixcount", pix_q.size(), 12);
    check("checker_pixel", qget(pix_q, 7), 0);
    $display("[%0d] checker frame: pixels=%0d fc=%0d", cyc, pix_q.size(), frame_count);

    // Pattern select change mid-frame
    clear_capture();
    pattern_sel = 2'd0;
    enable = 1'b1;
    repeat (20) @(negedge clk);
    pattern_sel = 2'd1;
    repeat (80) @(negedge clk);
    enable = 1'b0;
    wait_idle(100);
    check("selchg_frames", fs_q.size(), 2);
    for (int i = 0; i < 12; i++) check("selchg_f1_pixel", qget(pix_q, i), i % 4);
    for (int i = 20; i < 24; i++) check("selchg_f2_line2", qget(pix_q, i), 2);
    $display("[%0d] sel change: pixels=%0d fc=%0d", cyc, pix_q.size(), frame_count);

    // Drain after enable drop
    clear_capture();
    pattern_sel = 2'd0;
    enable = 1'b1;
    repeat (30) @(negedge clk);
    enable = 1'b0;
    wait_idle(100);
    check("drain_frames", fs_q.size(), 1);
    check("drain_pixcount", pix_q.size(), 12);
    check("drain_len", qget(fc_q, 0) - qget(fs_q, 0), 60);
    $display("[%0d] drain: pixels=%0d fc=%0d", cyc, pix_q.size(), frame_count);

    // Drop and re-enable during drain
    clear_capture();
    enable = 1'b1;
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_idle(100);
    check("reen_frames", fs_q.size(), 2);
    check("reen_period", qget(fs_q, 1) - qget(fs_q, 0), 60);
    check("reen_pixcount", pix_q.size(), 24);
    $display("[%0d] re-enable: frames=%0d fc=%0d", cyc, fs_q.size(), frame_count);

    // Reset mid-frame, then restart
    clear_capture();
    enable = 1'b1;
    repeat (25) @(negedge clk);
    rst = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_fc", frame_count, 0);
    check("rst_hblank", vid_hblank, 1);
    check("rst_vblank", vid_vblank, 1);
    check("rst_pixsync", vid_pixsync, 0);
    check("rst_pixel", vid_pixel, 0);
    clear_capture();
    pattern_sel = 2'd1;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    wait_idle(100);
    check("restart_frames", fs_q.size(), 1);
    check("restart_first_pixel", qget(pix_q, 0), 0);
    check("restart_line1_pixel", qget(pix_q, 4), 1);
    check("restart_fc", frame_count, 1);
    $display("[%0d] reset mid-frame + restart: pixels=%0d fc=%0d", cyc, pix_q.size(), frame_count);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
